// File: rtl/param_seq_detect_pkg.sv
// Shared state encoding and config helpers for the runtime-configurable sequence detector.
package param_seq_detect_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    function automatic logic cfg_len_ok(input int len, input int max_len);
        return (len >= 1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/param_seq_detect_hit_counter.sv
// Saturating hit counter; a clear always beats a simultaneous increment.
module seq_hit_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/param_seq_detect.sv
// Mealy serial-sequence detector with runtime pattern/length/overlap and a saturating hit count.
//   state | meaning
//   IDLE  | no legal configuration loaded yet, det held low
//   FILL  | collecting bits, fewer than len-1 held
//   ARMED | len-1 bits held, next qualified bit can complete a hit
module param_seq_detect
    import param_seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ser_in,
    input  logic               in_en,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               det,
    output logic               det_q,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic               armed,
    output logic               cfg_err
);

    state_t             state, state_nxt;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-2:0] hist, hist_nxt, hist_shift;
    logic [LEN_W-1:0]   fill, fill_nxt;
    logic [MAX_LEN-1:0] window, mask;
    logic               match, load_ok;

    assign load_ok    = cfg_len_ok(int'(cfg_len), MAX_LEN);
    assign window     = {hist, ser_in};
    assign hist_shift = (MAX_LEN-1)'(window);
    assign armed      = (state == ARMED);

    // Only the low len bits of the window/pattern take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    assign match = (((window ^ pat_q) & mask) == '0);

    always_comb begin
        state_nxt = state;
        hist_nxt  = hist;
        fill_nxt  = fill;
        det       = 1'b0;
        if (cfg_load) begin
            if (load_ok) begin
                hist_nxt  = '0;
                fill_nxt  = '0;
                state_nxt = (cfg_len == LEN_W'(1)) ? ARMED : FILL;
            end
        end else if (in_en) begin
            unique case (state)
                FILL: begin
                    hist_nxt = hist_shift;
                    fill_nxt = fill + LEN_W'(1);
                    if ((fill + LEN_W'(1)) == (len_q - LEN_W'(1))) begin
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (match) begin
                        det = 1'b1;
                        if (ovl_q) begin
                            hist_nxt = hist_shift;
                        end else begin
                            hist_nxt  = '0;
                            fill_nxt  = '0;
                            state_nxt = (len_q == LEN_W'(1)) ? ARMED : FILL;
                        end
                    end else begin
                        hist_nxt = hist_shift;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist    <= '0;
            fill    <= '0;
            det_q   <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            hist    <= hist_nxt;
            fill    <= fill_nxt;
            det_q   <= det;
            cfg_err <= cfg_load && !load_ok;
            if (cfg_load && load_ok) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                ovl_q <= cfg_overlap;
            end
        end
    end

    seq_hit_counter #(.CNT_W(CNT_W)) u_hit_counter (
        .clk (clk),
        .rst (rst),
        .inc (det),
        .clr (cnt_clr),
        .cnt (hit_cnt)
    );

endmodule
